// File: rtl/regfile_wb_if.sv
`default_nettype none
// ============================================================================
//  Module      : regfile_wb_if
//  Description : Bus interface for the regfile_wb register file. It groups
//                the MEM/WB writeback signals, the two ID-stage read
//                requests and the two registered read-data returns.
//                  master : pipeline side (drives write/read requests)
//                  slave  : register file side (returns read data)
//                Port summary (signal / direction as seen by the slave):
//                  write_i      in   writeback enable
//                  regw_addr_i  in   writeback destination register
//                  regw_data_i  in   writeback data
//                  re1_i/re2_i  in   read port enables
//                  raddr1_i/2_i in   read port addresses
//                  rdata1_o/2_o out  registered read data
//  Revision    : 1.0  initial release
// ============================================================================
interface regfile_wb_if #(
    parameter int DATA_W = 32,
    parameter int ADDR_W = 5
);
    logic              write_i;
    logic [ADDR_W-1:0] regw_addr_i;
    logic [DATA_W-1:0] regw_data_i;
    logic              re1_i;
    logic [ADDR_W-1:0] raddr1_i;
    logic              re2_i;
    logic [ADDR_W-1:0] raddr2_i;
    logic [DATA_W-1:0] rdata1_o;
    logic [DATA_W-1:0] rdata2_o;

    modport master (
        output write_i, regw_addr_i, regw_data_i,
        output re1_i, raddr1_i, re2_i, raddr2_i,
        input  rdata1_o, rdata2_o
    );

    modport slave (
        input  write_i, regw_addr_i, regw_data_i,
        input  re1_i, raddr1_i, re2_i, raddr2_i,
        output rdata1_o, rdata2_o
    );
endinterface
`default_nettype wire

// File: rtl/regfile_wb.sv
`default_nettype none
// ============================================================================
//  Module      : regfile_wb
//  Description : 32 x 32-bit integer register file with one writeback port
//                (from MEM/WB) and two registered read ports (to ID).
//                x0 is hardwired to zero. Read outputs hold while
//                stall[STALL_BIT] is set; writes always retire.
//                Optional macro REGFILE_BYPASS_EN: a read capturing in the
//                same cycle as a matching non-x0 write returns the write
//                data (write-first). Undefined: read-first (old value).
//  Ports       : clock  in   system clock, all state on posedge
//                reset  in   synchronous active-high reset
//                stall  in   6-bit pipeline stall vector
//                bus    slave modport of regfile_wb_if (write/read ports)
//  Revision    : 1.0  initial release
// ============================================================================
module regfile_wb #(
    parameter int DATA_W    = 32,
    parameter int ADDR_W    = 5,
    parameter int NREG      = 32,
    parameter int STALL_BIT = 1
) (
    input  wire logic       clock,
    input  wire logic       reset,
    input  wire logic [5:0] stall,
    regfile_wb_if.slave     bus
);

`ifdef REGFILE_BYPASS_EN
    localparam bit BYPASS = 1'b1;
`else
    localparam bit BYPASS = 1'b0;
`endif

    // Storage. Entry 0 is reset and never written, so it stays constant 0;
    // the read path also forces x0 to zero independently of the array.
    logic [DATA_W-1:0] mem_q [NREG];

    logic [DATA_W-1:0] rdata1_q, rdata1_d;
    logic [DATA_W-1:0] rdata2_q, rdata2_d;

    logic              w_stall_id;
    logic              w_wr_en;
    logic [DATA_W-1:0] w_mem_rd1;
    logic [DATA_W-1:0] w_mem_rd2;
    logic              w_unused_stall;

    assign w_stall_id     = stall[STALL_BIT];
    // Other stall bits belong to other pipeline stages.
    assign w_unused_stall = ^stall;
    assign w_wr_en        = bus.write_i && (bus.regw_addr_i != '0);

    assign w_mem_rd1 = mem_q[bus.raddr1_i];
    assign w_mem_rd2 = mem_q[bus.raddr2_i];

    // Value a read port captures when not stalled. The array value is the
    // pre-write content of this cycle; the bypass term substitutes the
    // in-flight writeback data when enabled.
    function automatic logic [DATA_W-1:0] capture(
        input logic              re,
        input logic [ADDR_W-1:0] raddr,
        input logic [DATA_W-1:0] mem_val,
        input logic              wr_en,
        input logic [ADDR_W-1:0] waddr,
        input logic [DATA_W-1:0] wdata
    );
        logic [DATA_W-1:0] v;
        v = '0;
        if (re && (raddr != '0)) begin
            if (BYPASS && wr_en && (waddr == raddr)) begin
                v = wdata;
            end else begin
                v = mem_val;
            end
        end
        return v;
    endfunction

    always_comb begin
        rdata1_d = rdata1_q;
        rdata2_d = rdata2_q;
        if (!w_stall_id) begin
            rdata1_d = capture(bus.re1_i, bus.raddr1_i, w_mem_rd1,
                               w_wr_en, bus.regw_addr_i, bus.regw_data_i);
            rdata2_d = capture(bus.re2_i, bus.raddr2_i, w_mem_rd2,
                               w_wr_en, bus.regw_addr_i, bus.regw_data_i);
        end
    end

    // Write port: never gated by stall, dropped under reset.
    always_ff @(posedge clock) begin
        if (reset) begin
            for (int i = 0; i < NREG; i++) begin
                mem_q[i] <= '0;
            end
        end else if (w_wr_en) begin
            mem_q[bus.regw_addr_i] <= bus.regw_data_i;
        end
    end

    // Registered read outputs; reset wins over stall.
    always_ff @(posedge clock) begin
        if (reset) begin
            rdata1_q <= '0;
            rdata2_q <= '0;
        end else begin
            rdata1_q <= rdata1_d;
            rdata2_q <= rdata2_d;
        end
    end

    assign bus.rdata1_o = rdata1_q;
    assign bus.rdata2_o = rdata2_q;

endmodule
`default_nettype wire
